// File: rtl/regfile_write_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter_if
//  Description : Bundle of the two requester write channels, the downstream
//                stall and the registered register-file write port.
//                "slave" is the arbiter side, "master" the surrounding logic.
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    // Requester 1 channel
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    // Requester 2 channel
    logic              req2_valid;
    logic [ADDR_W-1:0] req2_addr;
    logic [DATA_W-1:0] req2_data;
    logic              req2_ready;
    // Register-file write port and status
    logic              wr_hold;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_src;
    logic              busy;

    modport slave (
        input  req1_valid, req1_addr, req1_data,
        input  req2_valid, req2_addr, req2_data,
        input  wr_hold,
        output req1_ready, req2_ready,
        output wr_en, wr_addr, wr_data, wr_src, busy
    );

    modport master (
        output req1_valid, req1_addr, req1_data,
        output req2_valid, req2_addr, req2_data,
        output wr_hold,
        input  req1_ready, req2_ready,
        input  wr_en, wr_addr, wr_data, wr_src, busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Two-requester write arbiter in front of a single register
//                file write port. Each requester owns a DEPTH-entry circular
//                queue; one queued write per cycle is granted and issued on
//                registered write-port outputs. Per-requester order is kept.
//                Build option: REGARB_FIXED_PRIO_EN selects fixed priority
//                (requester 1 always wins); otherwise round-robin.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    regfile_write_arbiter_if.slave bus
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    // Per-requester views, index 0 = requester 1, index 1 = requester 2
    logic [1:0]        w_valid;
    logic [1:0]        w_ready;
    logic [1:0]        w_push;
    logic [1:0]        w_pop;
    logic [1:0]        w_nonempty;
    logic [ADDR_W-1:0] w_addr_in   [2];
    logic [DATA_W-1:0] w_data_in   [2];
    logic [ADDR_W-1:0] w_head_addr [2];
    logic [DATA_W-1:0] w_head_data [2];

    // Arbitration result: w_grant_sel 0 = requester 1, 1 = requester 2
    logic              w_hold;
    logic              w_grant_any;
    logic              w_grant_sel;
    logic [ADDR_W-1:0] w_issue_addr;
    logic [DATA_W-1:0] w_issue_data;

    // Registered write port
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_wr_src;

    assign w_valid      = {bus.req2_valid, bus.req1_valid};
    assign w_addr_in[0] = bus.req1_addr;
    assign w_addr_in[1] = bus.req2_addr;
    assign w_data_in[0] = bus.req1_data;
    assign w_data_in[1] = bus.req2_data;
    assign w_hold       = bus.wr_hold;

    // ------------------------------------------------------------------------
    // Request queues. Ready depends only on the count, so a full queue that
    // pops this cycle still refuses the incoming write.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < 2; k++) begin : g_queue
        logic [ADDR_W-1:0]  r_mem_addr [DEPTH];
        logic [DATA_W-1:0]  r_mem_data [DEPTH];
        logic [c_PTR_W-1:0] r_wptr;
        logic [c_PTR_W-1:0] r_rptr;
        logic [c_CNT_W-1:0] r_cnt;

        assign w_ready[k]     = (r_cnt != c_CNT_W'(DEPTH));
        assign w_nonempty[k]  = (r_cnt != '0);
        assign w_push[k]      = w_valid[k] & w_ready[k];
        assign w_head_addr[k] = r_mem_addr[r_rptr];
        assign w_head_data[k] = r_mem_data[r_rptr];

        // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_push[k]) begin
                    r_wptr <= r_wptr + c_PTR_W'(1);
                end
                if (w_pop[k]) begin
                    r_rptr <= r_rptr + c_PTR_W'(1);
                end
                case ({w_push[k], w_pop[k]})
                    2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                    2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end

        // Entry storage needs no reset: occupancy is governed by the count
        always_ff @(posedge clk) begin
            if (w_push[k]) begin
                r_mem_addr[r_wptr] <= w_addr_in[k];
                r_mem_data[r_wptr] <= w_data_in[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Arbitration. Grants look only at the registered counts, so an entry
    // pushed into an empty queue is first eligible on the following cycle.
    // ------------------------------------------------------------------------
`ifdef REGARB_FIXED_PRIO_EN
    // Fixed priority: requester 2 is served only when queue 1 is empty
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_sel = 1'b0;
        if (!w_hold && (w_nonempty != 2'b00)) begin
            w_grant_any = 1'b1;
            w_grant_sel = ~w_nonempty[0];
        end
    end
`else
    logic r_last_grant;

    // Round-robin: on contention grant the requester not served most recently
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_sel = 1'b0;
        if (!w_hold) begin
            if (w_nonempty == 2'b11) begin
                w_grant_any = 1'b1;
                w_grant_sel = ~r_last_grant;
            end else if (w_nonempty[0]) begin
                w_grant_any = 1'b1;
                w_grant_sel = 1'b0;
            end else if (w_nonempty[1]) begin
                w_grant_any = 1'b1;
                w_grant_sel = 1'b1;
            end
        end
    end

    // Remember the last real grant; starts at requester 2 so requester 1 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_grant_any) begin
            r_last_grant <= w_grant_sel;
        end
    end
`endif

    assign w_pop[0]     = w_grant_any & ~w_grant_sel;
    assign w_pop[1]     = w_grant_any &  w_grant_sel;
    assign w_issue_addr = w_grant_sel ? w_head_addr[1] : w_head_addr[0];
    assign w_issue_data = w_grant_sel ? w_head_data[1] : w_head_data[0];

    // Write port: enable pulses per grant, payload holds between grants
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_src  <= 1'b0;
        end else begin
            r_wr_en <= w_grant_any;
            if (w_grant_any) begin
                r_wr_addr <= w_issue_addr;
                r_wr_data <= w_issue_data;
                r_wr_src  <= w_grant_sel;
            end
        end
    end

    assign bus.req1_ready = w_ready[0];
    assign bus.req2_ready = w_ready[1];
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.wr_src     = r_wr_src;
    assign bus.busy       = |w_nonempty;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Self-checking bench for regfile_write_arbiter. Directed
//                scenarios plus randomized traffic against a queue-based
//                reference model of the arbitration rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    typedef struct packed {
        logic              s;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    // Reference model state
    ent_t              mq1[$];
    ent_t              mq2[$];
    bit                m_last;
    logic              m_en;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              m_src;
    logic [DATA_W-1:0] tb_rf [32];
    wr_t               seen[$];

    task automatic model_reset();
        mq1.delete();
        mq2.delete();
        m_last = 1'b1;
        m_en   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_src  = 1'b0;
    endtask

    // One clock of the arbitration rules, evaluated on pre-edge state and inputs
    task automatic model_step();
        int   n1;
        int   n2;
        int   g;
        bit   a1;
        bit   a2;
        ent_t e;
        n1 = mq1.size();
        n2 = mq2.size();
        g  = -1;
        if (bus.wr_hold !== 1'b1) begin
            if (n1 > 0 && n2 > 0) begin
`ifdef REGARB_FIXED_PRIO_EN
                g = 0;
`else
                g = m_last ? 0 : 1;
`endif
            end else if (n1 > 0) begin
                g = 0;
            end else if (n2 > 0) begin
                g = 1;
            end
        end
        a1 = (bus.req1_valid === 1'b1) && (n1 < DEPTH);
        a2 = (bus.req2_valid === 1'b1) && (n2 < DEPTH);
        if (g == 0) begin
            e = mq1.pop_front();
            m_en = 1'b1; m_addr = e.a; m_data = e.d; m_src = 1'b0; m_last = 1'b0;
        end else if (g == 1) begin
            e = mq2.pop_front();
            m_en = 1'b1; m_addr = e.a; m_data = e.d; m_src = 1'b1; m_last = 1'b1;
        end else begin
            m_en = 1'b0;
        end
        if (a1) mq1.push_back(ent_t'{a: bus.req1_addr, d: bus.req1_data});
        if (a2) mq2.push_back(ent_t'{a: bus.req2_addr, d: bus.req2_data});
    endtask

    // Advance one clock; the register file commits whatever wr_en presents at the edge
    task automatic cycle();
        if (bus.wr_en === 1'b1) tb_rf[bus.wr_addr] = bus.wr_data;
        model_step();
        @(posedge clk);
        #1;
        if (bus.wr_en === 1'b1) seen.push_back(wr_t'{s: bus.wr_src, a: bus.wr_addr, d: bus.wr_data});
    endtask

    task automatic idle_inputs();
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
        bus.req2_valid = 1'b0; bus.req2_addr = '0; bus.req2_data = '0;
        bus.wr_hold    = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        seen.delete();
        for (int i = 0; i < 32; i++) tb_rf[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (bus.wr_en !== 1'b0)  begin bad++; $display("FAIL rst_wr_en: got %b want 0", bus.wr_en); end
        total++; if (bus.wr_addr !== '0)  begin bad++; $display("FAIL rst_wr_addr: got %h want 0", bus.wr_addr); end
        total++; if (bus.wr_data !== '0)  begin bad++; $display("FAIL rst_wr_data: got %h want 0", bus.wr_data); end
        total++; if (bus.busy !== 1'b0)   begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        total++; if ({bus.req1_ready, bus.req2_ready} !== 2'b11) begin bad++; $display("FAIL rst_ready: got %b%b want 11", bus.req1_ready, bus.req2_ready); end
        // Queue traffic on both requesters, then reset while writes are pending
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 64'hA;
        bus.req2_valid = 1'b1; bus.req2_addr = 5'd3; bus.req2_data = 64'hB;
        cycle();
        bus.req1_addr = 5'd4; bus.req1_data = 64'hC;
        bus.req2_addr = 5'd5; bus.req2_data = 64'hD;
        cycle();
        idle_inputs();
        total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL pre_rst_wr_en: got %b want 1", bus.wr_en); end
        total++; if (bus.busy !== 1'b1)  begin bad++; $display("FAIL pre_rst_busy: got %b want 1", bus.busy); end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL async_rst_wr_en: got %b want 0", bus.wr_en); end
        total++; if (bus.busy !== 1'b0)  begin bad++; $display("FAIL async_rst_busy: got %b want 0", bus.busy); end
        total++; if ({bus.req1_ready, bus.req2_ready} !== 2'b11) begin bad++; $display("FAIL async_rst_ready: got %b%b want 11", bus.req1_ready, bus.req2_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL post_rst_no_write: cycle %0d got %b want 0", i, bus.wr_en); end
        end
    endtask

    task automatic test_single_write();
        apply_reset();
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 64'h1111111111111111;
        cycle();
        bus.req1_valid = 1'b0;
        total++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL single_edgeN: got en=%b busy=%b want en=0 busy=1", bus.wr_en, bus.busy); end
        cycle();
        total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd0 || bus.wr_data !== 64'h1111111111111111 || bus.wr_src !== 1'b0) begin
            bad++; $display("FAIL single_issue: got en=%b a=%h d=%h s=%b want en=1 a=00 d=1111111111111111 s=0", bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_src);
        end
        cycle();
        total++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL single_after: got en=%b busy=%b want 0 0", bus.wr_en, bus.busy); end
    endtask

    task automatic test_same_addr();
        apply_reset();
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd1; bus.req1_data = 64'h3333333333333333;
        bus.req2_valid = 1'b1; bus.req2_addr = 5'd1; bus.req2_data = 64'h4444444444444444;
        cycle();
        idle_inputs();
        cycle();
        total++; if (bus.wr_en !== 1'b1 || bus.wr_src !== 1'b0 || bus.wr_data !== 64'h3333333333333333) begin
            bad++; $display("FAIL same_addr_first: got en=%b s=%b d=%h want en=1 s=0 d=3333333333333333", bus.wr_en, bus.wr_src, bus.wr_data);
        end
        cycle();
        total++; if (bus.wr_en !== 1'b1 || bus.wr_src !== 1'b1 || bus.wr_data !== 64'h4444444444444444 || bus.wr_addr !== 5'd1) begin
            bad++; $display("FAIL same_addr_second: got en=%b s=%b a=%h d=%h want en=1 s=1 a=01 d=4444444444444444", bus.wr_en, bus.wr_src, bus.wr_addr, bus.wr_data);
        end
        cycle();
        total++; if (tb_rf[1] !== 64'h4444444444444444) begin bad++; $display("FAIL same_addr_final: got %h want 4444444444444444", tb_rf[1]); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL same_addr_idle: got %b want 0", bus.wr_en); end
    endtask

    task automatic test_back_to_back();
        int  i1 = 0;
        int  i2 = 0;
        int  k1 = 0;
        int  k2 = 0;
        bit  acc1;
        bit  acc2;
        bit  done = 1'b0;
        apply_reset();
        for (int c = 0; c < 60 && !done; c++) begin
            bus.req1_valid = (i1 < 8); bus.req1_addr = ADDR_W'(i1);      bus.req1_data = 64'h1000 + 64'(i1);
            bus.req2_valid = (i2 < 8); bus.req2_addr = ADDR_W'(16 + i2); bus.req2_data = 64'h2000 + 64'(i2);
            acc1 = bus.req1_valid && (bus.req1_ready === 1'b1);
            acc2 = bus.req2_valid && (bus.req2_ready === 1'b1);
            cycle();
            if (acc1) i1++;
            if (acc2) i2++;
            done = (i1 == 8) && (i2 == 8) && (seen.size() == 16);
        end
        idle_inputs();
        total++; if (!done) begin bad++; $display("FAIL b2b_timeout: got pushed=%0d/%0d issued=%0d want 8/8 16", i1, i2, seen.size()); end
        total++; if (seen.size() != 16) begin bad++; $display("FAIL b2b_count: got %0d want 16", seen.size()); end
        foreach (seen[j]) begin
            if (seen[j].s == 1'b0) begin
                total++; if (seen[j].d !== 64'h1000 + 64'(k1) || seen[j].a !== ADDR_W'(k1)) begin
                    bad++; $display("FAIL b2b_order_r1: idx %0d got a=%h d=%h want a=%h d=%h", j, seen[j].a, seen[j].d, ADDR_W'(k1), 64'h1000 + 64'(k1));
                end
                k1++;
            end else begin
                total++; if (seen[j].d !== 64'h2000 + 64'(k2) || seen[j].a !== ADDR_W'(16 + k2)) begin
                    bad++; $display("FAIL b2b_order_r2: idx %0d got a=%h d=%h want a=%h d=%h", j, seen[j].a, seen[j].d, ADDR_W'(16 + k2), 64'h2000 + 64'(k2));
                end
                k2++;
            end
`ifndef REGARB_FIXED_PRIO_EN
            total++; if (seen[j].s !== 1'(j % 2)) begin bad++; $display("FAIL b2b_alternate: idx %0d got src=%b want %0d", j, seen[j].s, j % 2); end
`endif
        end
    endtask

    task automatic test_full_hold();
        apply_reset();
        bus.wr_hold = 1'b1;
        bus.req2_valid = 1'b1; bus.req2_addr = 5'd7; bus.req2_data = 64'hAAAA;
        cycle();
        total++; if (bus.req2_ready !== 1'b1 || bus.wr_en !== 1'b0) begin bad++; $display("FAIL full_first: got rdy=%b en=%b want 1 0", bus.req2_ready, bus.wr_en); end
        bus.req2_addr = 5'd8; bus.req2_data = 64'hBBBB;
        cycle();
        total++; if (bus.req2_ready !== 1'b0) begin bad++; $display("FAIL full_second: got rdy=%b want 0", bus.req2_ready); end
        bus.req2_addr = 5'd9; bus.req2_data = 64'hCCCC;
        cycle();
        total++; if (bus.req2_ready !== 1'b0 || bus.wr_en !== 1'b0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL full_third: got rdy=%b en=%b busy=%b want 0 0 1", bus.req2_ready, bus.wr_en, bus.busy);
        end
        idle_inputs();
        cycle();
        total++; if (bus.wr_en !== 1'b1 || bus.wr_data !== 64'hAAAA || bus.wr_addr !== 5'd7 || bus.wr_src !== 1'b1 || bus.req2_ready !== 1'b1) begin
            bad++; $display("FAIL hold_release1: got en=%b a=%h d=%h s=%b rdy=%b want 1 07 aaaa 1 1", bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_src, bus.req2_ready);
        end
        cycle();
        total++; if (bus.wr_en !== 1'b1 || bus.wr_data !== 64'hBBBB || bus.wr_addr !== 5'd8) begin
            bad++; $display("FAIL hold_release2: got en=%b a=%h d=%h want 1 08 bbbb", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        cycle();
        total++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL hold_drained: got en=%b busy=%b want 0 0", bus.wr_en, bus.busy); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            bus.req1_valid = ($urandom_range(99) < 60);
            bus.req1_addr  = ADDR_W'($urandom);
            bus.req1_data  = {$urandom, $urandom};
            bus.req2_valid = ($urandom_range(99) < 60);
            bus.req2_addr  = ADDR_W'($urandom);
            bus.req2_data  = {$urandom, $urandom};
            bus.wr_hold    = ($urandom_range(99) < 25);
            cycle();
            total++; if (bus.wr_en !== m_en || bus.wr_addr !== m_addr || bus.wr_data !== m_data || bus.wr_src !== m_src) begin
                bad++; $display("FAIL rand_port: cyc %0d got en=%b a=%h d=%h s=%b want en=%b a=%h d=%h s=%b", c, bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_src, m_en, m_addr, m_data, m_src);
            end
            total++; if (bus.busy !== (mq1.size() != 0 || mq2.size() != 0) || bus.req1_ready !== (mq1.size() < DEPTH) || bus.req2_ready !== (mq2.size() < DEPTH)) begin
                bad++; $display("FAIL rand_status: cyc %0d got busy=%b r1=%b r2=%b want qsizes %0d %0d", c, bus.busy, bus.req1_ready, bus.req2_ready, mq1.size(), mq2.size());
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_single_write();
        test_same_addr();
        test_back_to_back();
        test_full_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
